dpi_stream_ctx_mgr: RTL and testbench

Parametrised per-stream context manager for a single regex DFA in the packet-inspection datapath. It saves and restores DFA state per stream ID, registers all DFA inputs and outputs for timing, and drains the DFA pipeline before committing so the last character's accept is never lost. It keeps a saturating per-stream match counter plus a global total, both readable by the host. It sits between the packet parser and an external DFA core.

---
 rtl/dpi_stream_ctx_mgr.sv | 201 ++++++++++++++++++++
 tb/tb_dpi_stream_ctx_mgr.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_stream_ctx_mgr.sv
// Per-stream context manager for one regex DFA: restores DFA state at packet start,
// drains the DFA pipeline after eop, then commits state and saturating match counts.
module dpi_stream_ctx_mgr #(
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = 6,
    parameter int STATE_W     = 11,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pkt_sop,
    input  logic [SID_W-1:0]   pkt_sid,
    input  logic               pkt_new_sid,
    input  logic               pkt_enable,
    input  logic [7:0]         char_in,
    input  logic               char_vld,
    input  logic               pkt_eop,
    output logic               run_rdy,
    output logic [7:0]         dfa_char,
    output logic               dfa_char_vld,
    output logic [STATE_W-1:0] dfa_state_ld,
    output logic               dfa_state_ld_vld,
    input  logic [STATE_W-1:0] dfa_state_cur,
    input  logic               dfa_accept,
    output logic               pkt_done,
    output logic               pkt_match,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [CNT_W-1:0]   rd_data,
    output logic               rd_vld,
    input  logic               clr_all,
    output logic [CNT_W-1:0]   total_count,
    output logic               proto_err
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN0, DRAIN1, COMMIT} fsm_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fsm_t                   fsm_q, fsm_d;
    logic [SID_W-1:0]       sid_q, sid_d;
    logic                   en_q, en_d;
    logic                   fired_q, fired_d;
    logic                   clr_pend_q, clr_pend_d;
    logic [NUM_STREAMS-1:0] valid_q, valid_d;
    logic [CNT_W-1:0]       total_q, total_d;
    logic [CNT_W-1:0]       rd_data_q, rd_data_d;
    logic                   rd_vld_q, rd_vld_d;
    logic                   proto_err_q, proto_err_d;
    logic                   run_rdy_q, run_rdy_d;
    logic                   pkt_done_q, pkt_done_d;
    logic                   pkt_match_q, pkt_match_d;
    logic                   ld_vld_q, ld_vld_d;
    logic [STATE_W-1:0]     ld_q, ld_d;
    logic                   char_vld_q, char_vld_d;
    logic [7:0]             char_q, char_d;
    logic                   acc_q;
    logic [STATE_W-1:0]     st_cur_q;

    logic [STATE_W-1:0]     state_mem [NUM_STREAMS];
    logic [CNT_W-1:0]       cnt_mem   [NUM_STREAMS];

    logic                   clr_now;
    logic                   commit_wr;
    logic [CNT_W-1:0]       cnt_base;
    logic [CNT_W-1:0]       cnt_new;

    always_comb begin
        clr_now   = (fsm_q == IDLE) && (clr_all || clr_pend_q);
        commit_wr = (fsm_q == COMMIT) && en_q;
        cnt_base  = valid_q[sid_q] ? cnt_mem[sid_q] : '0;
        cnt_new   = (fired_q && cnt_base != CNT_MAX) ? cnt_base + CNT_W'(1) : cnt_base;

        fsm_d       = fsm_q;
        sid_d       = sid_q;
        en_d        = en_q;
        fired_d     = fired_q;
        valid_d     = valid_q;
        total_d     = total_q;
        ld_d        = ld_q;
        clr_pend_d  = clr_pend_q | (clr_all && fsm_q != IDLE);
        proto_err_d = proto_err_q | (pkt_sop && fsm_q != IDLE)
                    | ((char_vld || pkt_eop) && fsm_q != RUN);
        char_vld_d  = char_vld && fsm_q == RUN;
        char_d      = char_vld_d ? char_in : char_q;

        case (fsm_q)
            IDLE: begin
                // A pending clear takes effect before a same-cycle sop looks up its context.
                if (clr_now) begin
                    valid_d    = '0;
                    total_d    = '0;
                    clr_pend_d = 1'b0;
                end
                if (pkt_sop) begin
                    fsm_d   = LOAD;
                    sid_d   = pkt_sid;
                    en_d    = pkt_enable;
                    fired_d = 1'b0;
                    ld_d    = (pkt_new_sid || clr_now || !valid_q[pkt_sid]) ? '0 : state_mem[pkt_sid];
                end
            end
            LOAD:   fsm_d = RUN;
            RUN: begin
                fired_d = fired_q | acc_q;
                if (pkt_eop) fsm_d = DRAIN0;
            end
            DRAIN0: begin
                fired_d = fired_q | acc_q;
                fsm_d   = DRAIN1;
            end
            DRAIN1: begin
                fired_d = fired_q | acc_q;
                fsm_d   = COMMIT;
            end
            COMMIT: begin
                fsm_d = IDLE;
                if (commit_wr) begin
                    valid_d[sid_q] = 1'b1;
                    if (fired_q && total_q != CNT_MAX) total_d = total_q + CNT_W'(1);
                end
            end
            default: fsm_d = IDLE;
        endcase

        run_rdy_d   = fsm_d == RUN;
        ld_vld_d    = fsm_d == LOAD;
        pkt_done_d  = fsm_d == COMMIT;
        pkt_match_d = (fsm_d == COMMIT) && en_q && fired_d;

        // A read of the stream being committed returns the post-commit count.
        rd_vld_d  = rd_en;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (commit_wr && rd_sid == sid_q) rd_data_d = cnt_new;
            else                              rd_data_d = valid_q[rd_sid] ? cnt_mem[rd_sid] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            sid_q       <= '0;
            en_q        <= 1'b0;
            fired_q     <= 1'b0;
            clr_pend_q  <= 1'b0;
            valid_q     <= '0;
            total_q     <= '0;
            rd_data_q   <= '0;
            rd_vld_q    <= 1'b0;
            proto_err_q <= 1'b0;
            run_rdy_q   <= 1'b0;
            pkt_done_q  <= 1'b0;
            pkt_match_q <= 1'b0;
            ld_vld_q    <= 1'b0;
            ld_q        <= '0;
            char_vld_q  <= 1'b0;
            char_q      <= '0;
            acc_q       <= 1'b0;
            st_cur_q    <= '0;
        end else begin
            fsm_q       <= fsm_d;
            sid_q       <= sid_d;
            en_q        <= en_d;
            fired_q     <= fired_d;
            clr_pend_q  <= clr_pend_d;
            valid_q     <= valid_d;
            total_q     <= total_d;
            rd_data_q   <= rd_data_d;
            rd_vld_q    <= rd_vld_d;
            proto_err_q <= proto_err_d;
            run_rdy_q   <= run_rdy_d;
            pkt_done_q  <= pkt_done_d;
            pkt_match_q <= pkt_match_d;
            ld_vld_q    <= ld_vld_d;
            ld_q        <= ld_d;
            char_vld_q  <= char_vld_d;
            char_q      <= char_d;
            acc_q       <= dfa_accept;
            st_cur_q    <= dfa_state_cur;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && commit_wr) begin
            state_mem[sid_q] <= st_cur_q;
            cnt_mem[sid_q]   <= cnt_new;
        end
    end

    assign run_rdy          = run_rdy_q;
    assign dfa_char         = char_q;
    assign dfa_char_vld     = char_vld_q;
    assign dfa_state_ld     = ld_q;
    assign dfa_state_ld_vld = ld_vld_q;
    assign pkt_done         = pkt_done_q;
    assign pkt_match        = pkt_match_q;
    assign rd_data          = rd_data_q;
    assign rd_vld           = rd_vld_q;
    assign total_count      = total_q;
    assign proto_err        = proto_err_q;
endmodule

// File: tb/tb_dpi_stream_ctx_mgr.sv
// Scoreboard bench for dpi_stream_ctx_mgr: a simple DFA core model drives the DUT's
// DFA interface; per-stream reference arrays predict loads, matches, reads and totals.
module tb_dpi_stream_ctx_mgr;
    localparam int NS  = 64;
    localparam int SW  = 6;
    localparam int STW = 11;
    localparam int CW  = 8;   // narrow counter so saturation is reachable quickly
    localparam logic [CW-1:0] CMAX = '1;

    logic           clk, rst_n;
    logic           pkt_sop, pkt_new_sid, pkt_enable, char_vld, pkt_eop;
    logic [SW-1:0]  pkt_sid, rd_sid;
    logic [7:0]     char_in, dfa_char;
    logic           run_rdy, dfa_char_vld, dfa_state_ld_vld, dfa_accept;
    logic [STW-1:0] dfa_state_ld, dfa_state_cur;
    logic           pkt_done, pkt_match, rd_en, rd_vld, clr_all, proto_err;
    logic [CW-1:0]  rd_data, total_count;

    dpi_stream_ctx_mgr #(.NUM_STREAMS(NS), .SID_W(SW), .STATE_W(STW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_sop(pkt_sop), .pkt_sid(pkt_sid),
        .pkt_new_sid(pkt_new_sid), .pkt_enable(pkt_enable), .char_in(char_in),
        .char_vld(char_vld), .pkt_eop(pkt_eop), .run_rdy(run_rdy), .dfa_char(dfa_char),
        .dfa_char_vld(dfa_char_vld), .dfa_state_ld(dfa_state_ld),
        .dfa_state_ld_vld(dfa_state_ld_vld), .dfa_state_cur(dfa_state_cur),
        .dfa_accept(dfa_accept), .pkt_done(pkt_done), .pkt_match(pkt_match),
        .rd_en(rd_en), .rd_sid(rd_sid), .rd_data(rd_data), .rd_vld(rd_vld),
        .clr_all(clr_all), .total_count(total_count), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy DFA: state shifts in the char behind the low 3 state bits; '!' accepts.
    function automatic logic [STW-1:0] nxt(input logic [STW-1:0] s, input logic [7:0] c);
        return {s[2:0], c};
    endfunction
    function automatic bit acc(input logic [7:0] c);
        return c == 8'h21;
    endfunction

    logic [STW-1:0] dfa_s;
    always @(posedge clk) begin
        if (!rst_n)                dfa_s <= '0;
        else if (dfa_state_ld_vld) dfa_s <= dfa_state_ld;
        else if (dfa_char_vld)     dfa_s <= nxt(dfa_s, dfa_char);
    end
    assign dfa_state_cur = dfa_s;
    assign dfa_accept    = dfa_char_vld && acc(dfa_char);

    int checks = 0;
    int errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model
    bit             m_valid [NS];
    logic [STW-1:0] m_state [NS];
    logic [CW-1:0]  m_cnt   [NS];
    logic [CW-1:0]  m_total;
    bit             m_err, m_clr_pend;

    logic [STW-1:0] q_ld[$];
    bit             q_match[$];
    logic [CW-1:0]  q_rd[$];
    logic [7:0]     pkt_chars[$];

    // Monitor: pops expectations whenever the DUT presents an output
    always @(negedge clk) begin
        if (rst_n) begin
            if (dfa_state_ld_vld) begin
                if (q_ld.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_load actual=%0h required=none", dfa_state_ld);
                end else chk("load_state", 32'(dfa_state_ld), 32'(q_ld.pop_front()));
            end
            if (pkt_done) begin
                if (q_match.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=%0b required=none", pkt_match);
                end else chk("pkt_match", 32'(pkt_match), 32'(q_match.pop_front()));
            end
            if (rd_vld) begin
                if (q_rd.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual=%0h required=none", rd_data);
                end else chk("rd_data", 32'(rd_data), 32'(q_rd.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NS; i++) m_valid[i] = 1'b0;
        m_total = '0;
    endtask

    task automatic do_read(input int sid);
        rd_en  = 1'b1;
        rd_sid = SW'(sid);
        q_rd.push_back(m_valid[sid] ? m_cnt[sid] : '0);
        tick();
        rd_en = 1'b0;
    endtask

    // Entered and left in an IDLE cycle; the next sop may follow immediately.
    task automatic send_pkt(input int sid, input bit nsid, input bit en, input bit eop_alone,
                            input bit err_load, input bit err_sop, input bit clr_run,
                            input bit clr_sop, input bit bypass);
        logic [STW-1:0] s;
        bit             fired;
        int             n;
        if (clr_sop) begin
            clr_all = 1'b1;
            model_clear();
        end
        s = (nsid || !m_valid[sid]) ? '0 : m_state[sid];
        q_ld.push_back(s);
        pkt_sop = 1'b1; pkt_sid = SW'(sid); pkt_new_sid = nsid; pkt_enable = en;
        tick();
        pkt_sop = 1'b0; clr_all = 1'b0;
        pkt_sid = SW'($urandom); pkt_new_sid = 1'($urandom); pkt_enable = 1'($urandom);
        if (err_load) begin
            char_vld = 1'b1; char_in = 8'h21; m_err = 1'b1;
        end
        tick();
        char_vld = 1'b0;
        if (err_sop) begin
            pkt_sop = 1'b1; pkt_sid = SW'(sid ^ 1); m_err = 1'b1;
            tick();
            pkt_sop = 1'b0;
        end
        if (clr_run) begin
            clr_all = 1'b1; m_clr_pend = 1'b1;
            tick();
            clr_all = 1'b0;
        end
        fired = 1'b0;
        n = pkt_chars.size();
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(0, 3) == 0) tick();
            char_in  = pkt_chars[i];
            char_vld = 1'b1;
            pkt_eop  = (i == n - 1) && !eop_alone;
            s        = nxt(s, char_in);
            fired    = fired | acc(char_in);
            tick();
            char_vld = 1'b0; pkt_eop = 1'b0; char_in = 8'($urandom);
        end
        if (n == 0 || eop_alone) begin
            pkt_eop = 1'b1;
            tick();
            pkt_eop = 1'b0;
        end
        q_match.push_back(en && fired);
        if (en) begin
            if (!m_valid[sid]) m_cnt[sid] = '0;
            if (fired && m_cnt[sid] != CMAX) m_cnt[sid] = m_cnt[sid] + 1'b1;
            if (fired && m_total != CMAX) m_total = m_total + 1'b1;
            m_valid[sid] = 1'b1;
            m_state[sid] = s;
        end
        tick();
        tick();
        if (bypass) begin
            rd_en = 1'b1; rd_sid = SW'(sid);
            q_rd.push_back(m_valid[sid] ? m_cnt[sid] : '0);
        end
        tick();
        rd_en = 1'b0;
        chk("total_count", 32'(total_count), 32'(m_total));
        chk("proto_err", 32'(proto_err), 32'(m_err));
        if (m_clr_pend) begin
            model_clear();
            m_clr_pend = 1'b0;
            tick();
        end
    endtask

    task automatic rand_chars(input int n);
        pkt_chars.delete();
        for (int i = 0; i < n; i++)
            pkt_chars.push_back(($urandom_range(0, 3) == 0) ? 8'h21 : 8'($urandom));
    endtask

    initial begin
        rst_n = 1'b0; pkt_sop = 1'b0; pkt_sid = '0; pkt_new_sid = 1'b0; pkt_enable = 1'b0;
        char_in = '0; char_vld = 1'b0; pkt_eop = 1'b0; rd_en = 1'b0; rd_sid = '0; clr_all = 1'b0;
        model_clear();
        m_err = 1'b0; m_clr_pend = 1'b0;
        repeat (3) tick();
        chk("rst_run_rdy", 32'(run_rdy), 32'(0));
        chk("rst_pkt_done", 32'(pkt_done), 32'(0));
        chk("rst_ld_vld", 32'(dfa_state_ld_vld), 32'(0));
        chk("rst_char_vld", 32'(dfa_char_vld), 32'(0));
        chk("rst_rd_vld", 32'(rd_vld), 32'(0));
        chk("rst_total", 32'(total_count), 32'(0));
        chk("rst_proto_err", 32'(proto_err), 32'(0));
        rst_n = 1'b1;
        tick();

        // New stream, accept on the eop char, bypass read at commit
        pkt_chars = '{8'h41, 8'h42, 8'h21};
        send_pkt(3, 1, 1, 0, 0, 0, 0, 0, 1);
        do_read(3);

        // Back-to-back on one sid: second load must see 0x2A5
        pkt_chars = '{8'h02, 8'hA5};
        send_pkt(7, 1, 1, 0, 0, 0, 0, 0, 0);
        pkt_chars = '{8'h10};
        send_pkt(7, 0, 1, 0, 0, 0, 0, 0, 0);

        // Disabled stream: no commit, next packet loads 0
        pkt_chars = '{8'h21};
        send_pkt(9, 0, 0, 0, 0, 0, 0, 0, 1);
        do_read(9);
        pkt_chars = '{8'h55};
        send_pkt(9, 0, 1, 0, 0, 0, 0, 0, 0);

        // Saturation on sid 5
        for (int k = 0; k < int'(CMAX) + 2; k++) begin
            pkt_chars = '{8'h21};
            send_pkt(5, 1'(k), 1, 0, 0, 0, 0, 0, k >= int'(CMAX) - 1);
        end
        do_read(5);

        // clr_all during RUN, then reads and a fresh load
        pkt_chars = '{8'h21, 8'h33};
        send_pkt(11, 0, 1, 0, 0, 0, 1, 0, 0);
        do_read(3); do_read(5); do_read(7); do_read(9); do_read(11);
        send_pkt(3, 0, 1, 0, 0, 0, 0, 0, 1);
        // clr_all together with sop
        pkt_chars = '{8'h21};
        send_pkt(3, 0, 1, 0, 0, 0, 0, 1, 1);

        // Protocol violations during LOAD and RUN; packet still commits
        pkt_chars = '{8'h21, 8'h07};
        send_pkt(12, 1, 1, 0, 1, 1, 0, 0, 1);
        do_read(12);

        // Randomized traffic
        for (int k = 0; k < 150; k++) begin
            rand_chars($urandom_range(0, 5));
            send_pkt($urandom_range(0, 15), $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                     $urandom_range(0, 19) == 0, $urandom_range(0, 24) == 0,
                     $urandom_range(0, 24) == 0, $urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1) == 1) do_read($urandom_range(0, 15));
        end

        // Reset in the middle of a packet: never committed, contexts invalidated
        q_ld.push_back(m_valid[4] ? m_state[4] : '0);
        pkt_sop = 1'b1; pkt_sid = SW'(4); pkt_new_sid = 1'b0; pkt_enable = 1'b1;
        tick();
        pkt_sop = 1'b0;
        tick();
        char_in = 8'h21; char_vld = 1'b1;
        tick();
        char_vld = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        model_clear();
        m_err = 1'b0;
        m_clr_pend = 1'b0;
        tick();
        chk("post_rst_total", 32'(total_count), 32'(m_total));
        chk("post_rst_proto_err", 32'(proto_err), 32'(m_err));
        do_read(3); do_read(4);
        pkt_chars = '{8'h21};
        send_pkt(4, 0, 1, 0, 0, 0, 0, 0, 1);

        repeat (5) tick();
        chk("pending_loads", 32'(q_ld.size()), 32'(0));
        chk("pending_dones", 32'(q_match.size()), 32'(0));
        chk("pending_reads", 32'(q_rd.size()), 32'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
